// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
// Holds the FSM state encoding, datapath widths and small helpers.
package reaction_pkg;

   localparam int DelayW        = 13;
   localparam int TimeW         = 10;
   localparam int MaxReactMsDef = 999;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_GO    = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAULT = 3'd4
   } state_e;

   function automatic logic rose(
      input logic cur,
      input logic prev
   );
      return cur & ~prev;
   endfunction

   function automatic logic [TimeW-1:0] min_time(
      input logic [TimeW-1:0] a,
      input logic [TimeW-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..ClksPerMs-1, Tick high on terminal count.
// Ports: Clk, Rst (async active-low), Clr (sync restart from 0), Tick (1-cycle pulse).
module ms_tick #(
   parameter int ClksPerMs = 50000
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Clr,
   output logic Tick
);

   localparam int CntW = (ClksPerMs > 1) ? $clog2(ClksPerMs) : 1;
   localparam logic [CntW-1:0] Last = CntW'(ClksPerMs - 1);

   logic [CntW-1:0] cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt <= '0;
      end else if (Clr) begin
         cnt <= '0;
      end else if (cnt == Last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign Tick = (cnt == Last);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time controller: random delay, go LED, ms reaction count, fault flags.
// Ports: Clk, Rst, Start, React, RandomValue -> Led, ReactionTime, Valid,
// Early, Timeout, State; BestTime when BEST_TIME_EN is defined.
module reaction_timer
   import reaction_pkg::*;
#(
   parameter int ClksPerMs  = 50000,
   parameter int MaxReactMs = MaxReactMsDef
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic              React,
   input  logic [DelayW-1:0] RandomValue,
   output logic              Led,
   output logic [TimeW-1:0]  ReactionTime,
   output logic              Valid,
   output logic              Early,
   output logic              Timeout,
`ifdef BEST_TIME_EN
   output logic [TimeW-1:0]  BestTime,
`endif
   output logic [2:0]        State
);

   localparam logic [DelayW-1:0] MaxMs = DelayW'(MaxReactMs);

   state_e            state;
   logic              start_q;
   logic              react_q;
   logic              start_rise;
   logic              react_rise;
   logic              start_ok;
   logic              tick;
   logic [DelayW-1:0] delay_reg;
   logic [DelayW-1:0] ms_cnt;
   logic [DelayW-1:0] ms_next;

   assign start_rise = rose(Start, start_q);
   assign react_rise = rose(React, react_q);

   // A start is honoured only between trials; it also restarts the prescaler
   // so the first ms tick lands a full period after the press.
   assign start_ok = start_rise &
                     ((state == ST_IDLE) ||
                      (state == ST_DONE) ||
                      (state == ST_FAULT));

   assign ms_next = ms_cnt + DelayW'(1);

   ms_tick #(
      .ClksPerMs(ClksPerMs)
   ) u_tick (
      .Clk (Clk),
      .Rst (Rst),
      .Clr (start_ok),
      .Tick(tick)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state        <= ST_IDLE;
         start_q      <= 1'b0;
         react_q      <= 1'b0;
         delay_reg    <= '0;
         ms_cnt       <= '0;
         Led          <= 1'b0;
         ReactionTime <= '0;
         Valid        <= 1'b0;
         Early        <= 1'b0;
         Timeout      <= 1'b0;
      end else begin
         start_q <= Start;
         react_q <= React;
         Valid   <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
               if (start_ok) begin
                  state     <= ST_WAIT;
                  delay_reg <= RandomValue;
                  ms_cnt    <= '0;
                  Early     <= 1'b0;
                  Timeout   <= 1'b0;
               end
            end
            ST_WAIT: begin
               // React wins over a coincident delay completion.
               if (react_rise) begin
                  state <= ST_FAULT;
                  Early <= 1'b1;
               end else if (tick) begin
                  // >= lets a zero delay finish on the first tick.
                  if (ms_next >= delay_reg) begin
                     state  <= ST_GO;
                     ms_cnt <= '0;
                     Led    <= 1'b1;
                  end else begin
                     ms_cnt <= ms_next;
                  end
               end
            end
            ST_GO: begin
               // Capture the pre-increment count even if a tick coincides.
               if (react_rise) begin
                  state        <= ST_DONE;
                  Led          <= 1'b0;
                  ReactionTime <= ms_cnt[TimeW-1:0];
                  Valid        <= 1'b1;
               end else if (tick) begin
                  ms_cnt <= ms_next;
                  if (ms_next >= MaxMs) begin
                     state        <= ST_FAULT;
                     Led          <= 1'b0;
                     Timeout      <= 1'b1;
                     ReactionTime <= MaxMs[TimeW-1:0];
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               Led   <= 1'b0;
            end
         endcase
      end
   end

`ifdef BEST_TIME_EN
   // Updated together with the Valid capture; survives Start.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         BestTime <= '1;
      end else if ((state == ST_GO) && react_rise) begin
         BestTime <= min_time(BestTime, ms_cnt[TimeW-1:0]);
      end
   end
`endif

   assign State = state;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with a 4-clock millisecond.
// Expected timing is computed from tick arithmetic, not from the FSM.
module tb_reaction_timer;

   localparam int K     = 4;
   localparam int MaxMs = 999;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic        React = 1'b0;
   logic [12:0] RandomValue = '0;
   logic        Led;
   logic [9:0]  ReactionTime;
   logic        Valid;
   logic        Early;
   logic        Timeout;
   logic [2:0]  State;
`ifdef BEST_TIME_EN
   logic [9:0]  BestTime;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int vcnt = 0;
   int vdouble = 0;
   int led_cnt = 0;
   logic v_prev = 1'b0;

   reaction_timer #(
      .ClksPerMs (K),
      .MaxReactMs(MaxMs)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Start       (Start),
      .React       (React),
      .RandomValue (RandomValue),
      .Led         (Led),
      .ReactionTime(ReactionTime),
      .Valid       (Valid),
      .Early       (Early),
      .Timeout     (Timeout),
`ifdef BEST_TIME_EN
      .BestTime    (BestTime),
`endif
      .State       (State)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc++;

   always @(negedge Clk) begin
      if (Valid) vcnt++;
      if (Valid && v_prev) vdouble++;
      v_prev = Valid;
      if (Led) led_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge Clk);
      #1;
   endtask

   task automatic run_to(input int p);
      int n;
      n = 0;
      while (cyc < p && n < 100000) begin
         step();
         n++;
      end
   endtask

   // Posedge index at which Led first shows high for delay d from start E.
   function automatic int exp_led(input int e, input int d);
      return e + K * ((d == 0) ? 1 : d);
   endfunction

   // Whole ms ticks elapsed in GO strictly before the react sample edge.
   function automatic int exp_rt(input int l, input int p);
      return (p - l - 1) / K;
   endfunction

   task automatic do_start(input int d, output int e);
      RandomValue = 13'(d);
      Start = 1'b1;
      e = cyc + 1;
      step();
      Start = 1'b0;
      chk("start_state", 32'(State), 1);
      chk("start_early_clr", 32'(Early), 0);
      chk("start_tmo_clr", 32'(Timeout), 0);
   endtask

   task automatic wait_led(input int limit, output int l);
      while (!Led && cyc < limit) step();
      l = Led ? cyc : -1;
   endtask

   task automatic react_at(input int p);
      run_to(p - 1);
      React = 1'b1;
      step();
   endtask

   initial begin
      int e, l, p, d, r, v0, lc0, t, best_m;
      int tvals[3];
      tvals[0] = 300;
      tvals[1] = 200;
      tvals[2] = 250;

      repeat (3) step();
      chk("rst_state", 32'(State), 0);
      chk("rst_led", 32'(Led), 0);
      chk("rst_rt", 32'(ReactionTime), 0);
      chk("rst_valid", 32'(Valid), 0);
      chk("rst_early", 32'(Early), 0);
      chk("rst_tmo", 32'(Timeout), 0);
      Rst = 1'b1;
      repeat (2) step();

      // Normal trial
      do_start(1000, e);
      wait_led(e + K * 1000 + 8, l);
      chk("norm_led_rise", 32'(l), 32'(exp_led(e, 1000)));
      p = l + K * 250 + int'($urandom_range(1, K));
      v0 = vcnt;
      react_at(p);
      chk("norm_rt", 32'(ReactionTime), 32'(exp_rt(l, p)));
      chk("norm_valid", 32'(Valid), 1);
      chk("norm_state", 32'(State), 3);
      chk("norm_led_off", 32'(Led), 0);
      step();
      chk("norm_valid_drop", 32'(Valid), 0);
      repeat (5) step();
      chk("held_react_once", 32'(vcnt - v0), 1);
      React = 1'b0;
      step();

      // False start
      lc0 = led_cnt;
      v0 = vcnt;
      do_start(3000, e);
      p = e + K * 1500 + int'($urandom_range(0, K - 1));
      react_at(p);
      chk("early_state", 32'(State), 4);
      chk("early_flag", 32'(Early), 1);
      repeat (3) step();
      React = 1'b0;
      step();
      chk("early_no_led", 32'(led_cnt - lc0), 0);
      chk("early_no_valid", 32'(vcnt - v0), 0);
      chk("early_rt_hold", 32'(ReactionTime), 250);

      // Timeout
      v0 = vcnt;
      do_start(1000, e);
      wait_led(e + K * 1000 + 8, l);
      chk("tmo_led_rise", 32'(l), 32'(exp_led(e, 1000)));
      run_to(l + K * MaxMs - 1);
      chk("tmo_pre_state", 32'(State), 2);
      chk("tmo_pre_led", 32'(Led), 1);
      step();
      chk("tmo_state", 32'(State), 4);
      chk("tmo_flag", 32'(Timeout), 1);
      chk("tmo_rt", 32'(ReactionTime), 32'(MaxMs));
      chk("tmo_led", 32'(Led), 0);
      chk("tmo_no_valid", 32'(vcnt - v0), 0);

      // React on the final WAIT tick
      d = int'($urandom_range(5, 60));
      lc0 = led_cnt;
      do_start(d, e);
      react_at(e + K * d);
      chk("simul_state", 32'(State), 4);
      chk("simul_early", 32'(Early), 1);
      step();
      chk("simul_no_led", 32'(led_cnt - lc0), 0);
      React = 1'b0;
      step();

      // React on a GO tick at count 42
      d = int'($urandom_range(1, 50));
      do_start(d, e);
      wait_led(e + K * d + 8, l);
      chk("c42_led_rise", 32'(l), 32'(exp_led(e, d)));
      p = l + K * 43;
      react_at(p);
      chk("c42_rt", 32'(ReactionTime), 32'(exp_rt(l, p)));
      chk("c42_rt_lit", 32'(ReactionTime), 42);
      chk("c42_valid", 32'(Valid), 1);
      React = 1'b0;
      step();

      // Zero delay leaves WAIT on the first tick
      do_start(0, e);
      wait_led(e + K + 8, l);
      chk("d0_led_rise", 32'(l), 32'(exp_led(e, 0)));
      p = l + int'($urandom_range(1, K * 30));
      react_at(p);
      chk("d0_rt", 32'(ReactionTime), 32'(exp_rt(l, p)));
      React = 1'b0;
      step();

      // Start during WAIT is ignored
      d = int'($urandom_range(1000, 1300));
      do_start(d, e);
      run_to(e + K * 500);
      RandomValue = 13'd50;
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      chk("ign_state", 32'(State), 1);
      wait_led(e + K * d + 8, l);
      chk("ign_led_rise", 32'(l), 32'(exp_led(e, d)));
      p = l + K * 10 + 1;
      react_at(p);
      chk("ign_rt", 32'(ReactionTime), 10);
      React = 1'b0;
      step();

      // Random trials
      for (int i = 0; i < 4; i++) begin
         d = int'($urandom_range(1, 200));
         do_start(d, e);
         wait_led(e + K * d + 8, l);
         chk("rnd_led_rise", 32'(l), 32'(exp_led(e, d)));
         r = int'($urandom_range(1, K * 400));
         react_at(l + r);
         chk("rnd_rt", 32'(ReactionTime), 32'(exp_rt(l, l + r)));
         chk("rnd_valid", 32'(Valid), 1);
         React = 1'b0;
         step();
      end

      // Asynchronous reset mid-GO
      d = int'($urandom_range(1, 20));
      do_start(d, e);
      wait_led(e + K * d + 8, l);
      repeat (7) step();
      Rst = 1'b0;
      #1;
      chk("arst_state", 32'(State), 0);
      chk("arst_led", 32'(Led), 0);
      chk("arst_rt", 32'(ReactionTime), 0);
      chk("arst_valid", 32'(Valid), 0);
`ifdef BEST_TIME_EN
      chk("arst_best", 32'(BestTime), 32'h3FF);
`endif
      step();
      Rst = 1'b1;
      step();
      chk("arst_idle", 32'(State), 0);

      // Best-time trials
      best_m = 32'h3FF;
      for (int i = 0; i < 3; i++) begin
         t = tvals[i];
         d = int'($urandom_range(1, 20));
         do_start(d, e);
         wait_led(e + K * d + 8, l);
         p = l + K * t + 1;
         react_at(p);
         chk("best_rt", 32'(ReactionTime), 32'(t));
         if (t < best_m) best_m = t;
`ifdef BEST_TIME_EN
         chk("best_val", 32'(BestTime), 32'(best_m));
`endif
         React = 1'b0;
         step();
      end
      do_start(100, e);
`ifdef BEST_TIME_EN
      chk("best_after_start", 32'(BestTime), 200);
`endif
      chk("no_double_valid", 32'(vdouble), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Reaction-time measurement controller that consumes the 13-bit random delay produced by the random generator stage (values 1000–6000, in milliseconds). On a start press it latches the delay, waits that many milliseconds, lights the go LED and counts milliseconds until the react press. It reports the reaction time, or flags a false start or timeout, to the display stage downstream.

## Interface
Parameters:
- ClksPerMs, 50000, clock cycles per millisecond tick (50 MHz default)
- MaxReactMs, 999, reaction-count ceiling; reaching it is a timeout

Ports:
- Clk  in  1  system clock, all logic on posedge
- Rst  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- Start  in  1  synchronous, debounced start button level
- React  in  1  synchronous, debounced react button level
- RandomValue  in  13  delay in ms from the random generator, sampled on start
- Led  out  1  go indicator, high only in GO
- ReactionTime  out  10  last captured reaction time in ms
- Valid  out  1  one-cycle pulse when ReactionTime updates from a good trial
- Early  out  1  sticky false-start flag, cleared on next start
- Timeout  out  1  sticky timeout flag, cleared on next start
- State  out  3  current FSM state encoding, for debug and display

## Operation
- Start and React are rising-edge detected internally (one register each). A held button counts once.
- States: IDLE, WAIT, GO, DONE, FAULT.
- IDLE, DONE or FAULT + Start edge -> WAIT:
  - DelayReg <= RandomValue.
  - Tick counter and ms counter are cleared.
  - Early and Timeout are cleared.
- WAIT: the ms counter increments on each tick.
  - When the count equals DelayReg, go to GO and clear the ms counter.
  - React edge -> FAULT with Early=1. React beats a simultaneous delay completion.
- GO: Led=1; the ms counter increments on each tick.
  - React edge -> DONE; ReactionTime <= current count (pre-increment if a tick coincides); Valid=1 for one cycle.
  - Count reaching MaxReactMs -> FAULT, Timeout=1, ReactionTime <= MaxReactMs. Valid is not asserted.
- DONE / FAULT: hold all outputs. Only a Start edge leaves these states.
- Start edges in WAIT or GO are ignored. React edges in IDLE, DONE or FAULT are ignored.
- Arithmetic:
  - The ms counter is 13 bits and unsigned.
  - The ms counter never wraps: WAIT exits at most at 6000; the GO count saturates at MaxReactMs.
  - ReactionTime is the low 10 bits of the ms counter.
- RandomValue outside 1000–6000 is accepted unchanged. A value of 0 makes WAIT exit on the first tick.

## Timing
- Reset value of every output, and all internal registers, is 0. State resets to IDLE.
- Reset mid-trial aborts immediately: asynchronous assert, synchronous release.
- Tick timing:
  - The tick prescaler counts 0..ClksPerMs-1 and asserts tick on the terminal count.
  - The prescaler restarts from 0 on the WAIT entry cycle, so the first tick comes ClksPerMs cycles after the Start edge is registered.
- Latencies:
  - Start edge -> State=WAIT: 1 cycle after the edge-detect register.
  - Delay completion tick -> Led=1: 1 cycle.
  - React edge -> Valid and ReactionTime: same registered update, 1 cycle after the edge is detected.
  - Led drops in the same cycle as the DONE/FAULT transition.
- Valid is never high for two consecutive cycles.

## Configuration
- BEST_TIME_EN defined:
  - Adds output BestTime[9:0], reset to 10'h3FF.
  - On every Valid, BestTime <= min(BestTime, ReactionTime).
  - Start does not clear it; only Rst does.
- BEST_TIME_EN undefined: no BestTime port or register. All other behaviour is identical.

## Structure
- Shared package reaction_pkg:
  - State encoding constants: IDLE=0, WAIT=1, GO=2, DONE=3, FAULT=4.
  - DelayW=13, TimeW=10.
  - Default MaxReactMs.
- Sub-module ms_tick:
  - Parameterised prescaler with synchronous clear input.
  - Outputs a one-cycle tick.
  - Instantiated once.
- FSM, edge detectors and capture registers live in reaction_timer.

## Test plan
Bench uses ClksPerMs=4.
- Normal trial: RandomValue=1000, Start edge; React edge 250 ms after Led rises -> Led high after exactly 1000 ticks, Valid one cycle, ReactionTime=250, State=DONE.
- False start: RandomValue=3000, React edge at 1500 ms -> State=FAULT, Early=1, Led never high, Valid never asserted.
- Timeout: RandomValue=1000, no React -> FAULT after 999 ms of GO, Timeout=1, ReactionTime=999, Led low.
- Simultaneous events:
  - React edge on the same cycle as the final WAIT tick -> FAULT with Early=1.
  - React edge coinciding with a GO tick at count 42 -> ReactionTime=42.
- Ignored inputs and reset:
  - Start edge pulsed during WAIT -> DelayReg unchanged, completion time unchanged.
  - Held React after DONE -> no second Valid.
  - Rst low mid-GO -> all outputs 0 and IDLE asynchronously.
- BEST_TIME_EN: trials of 300, 200, 250 ms -> BestTime 300, 200, 200. A Start after them leaves BestTime=200.
